wave_capture_ctrl: RTL and testbench
====================================

Name: wave_capture_ctrl

Overview:
- Sequences capture of ADC sample bytes into a two-bank, 640-entry waveform buffer that the VGA dot generator reads one byte per visible column.
- Provides trigger detection by level and slope, sample decimation, auto-trigger timeout, and a ping-pong bank swap.
- The bank swap is committed only on a vertical-blank rising edge, so a displayed frame never tears.
- Sits between the ADC sample stream and the waveform buffer RAM; the display side reads bank dispBank.

Parameters:
- H_VISIBLE, 640, samples per captured frame (one per visible column)
- ADDR_W, 10, buffer address width
- DATA_W, 8, sample width
- AUTO_W, 16, width of auto-trigger timeout counter

Ports:
- Clk  input  1  system clock, all logic on rising edge
- vgaRst  input  1  asynchronous active-low reset
- sampleValid  input  1  one-cycle strobe: sampleData valid
- sampleData  input  DATA_W  ADC sample
- armEnable  input  1  level; 1 = continuous re-arm
- forceTrig  input  1  pulse; trigger on next valid sample while ARMED
- trigSlope  input  1  0 = rising, 1 = falling
- trigLevel  input  DATA_W  trigger threshold
- decimation  input  8  store one of every decimation+1 valid samples
- autoMode  input  1  enable timeout trigger
- autoTimeout  input  AUTO_W  valid samples to wait in ARMED before forced trigger
- vBlank  input  1  vertical blanking level from sync generator
- wrEn  output  1  buffer write strobe
- wrAddr  output  ADDR_W  buffer write address
- wrData  output  DATA_W  buffer write data
- wrBank  output  1  bank being written; always ~dispBank
- dispBank  output  1  bank the display reads
- captureDone  output  1  one-cycle pulse when the last address is written
- state  output  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 WAIT_SWAP

Behaviour:
- Reset (async, vgaRst=0) forces the following values:
  - state=IDLE, wrEn=0, wrAddr=0, wrData=0, dispBank=0 (so wrBank=1), captureDone=0
  - prevSample=0, prevValid=0, decimation count=0, auto count=0, vBlankPrev=0
- Reset takes effect mid-capture; the partial frame is abandoned and dispBank returns to 0.
- IDLE:
  - armEnable=1 -> ARMED next cycle.
  - Clears prevValid and the auto counter.
- ARMED, on each sampleValid:
  - Update prevSample and set prevValid.
  - Rising trigger: prevValid & prevSample<trigLevel & sampleData>=trigLevel.
  - Falling trigger: prevValid & prevSample>trigLevel & sampleData<=trigLevel.
  - forceTrig (pending since it pulsed while ARMED) triggers on the next valid sample.
  - autoMode=1 and auto count==autoTimeout-1 also triggers; otherwise the count increments.
  - Any trigger source, or several in the same cycle, yields exactly one trigger.
  - On trigger: the triggering sample is written to address 0, the decimation count loads decimation, and state goes to CAPTURE.
  - armEnable=0 in ARMED -> IDLE next cycle, with no write.
- CAPTURE, on each sampleValid:
  - Decimation count==0: write the sample at the next address and reload the count.
  - Otherwise: decrement the count.
  - armEnable is ignored; a started frame always completes.
- Write timing:
  - wrEn, wrAddr and wrData are registered and assert exactly one cycle after the sampleValid cycle they belong to.
  - wrEn is high for one cycle per stored sample.
  - wrAddr increments 0..H_VISIBLE-1 with no wrap.
- Frame completion:
  - The write at H_VISIBLE-1 pulses captureDone in the same cycle as that wrEn.
  - state=WAIT_SWAP from the following cycle.
- WAIT_SWAP:
  - Rising edge detect is vBlank & ~vBlankPrev, registered every cycle.
  - Only an edge seen in WAIT_SWAP counts; if vBlank is already high on entry, wait for the next edge.
  - On the edge: toggle dispBank, then go to ARMED if armEnable=1, else IDLE.
  - The auto counter and prevValid clear on the swap.
  - Samples are ignored and no writes occur in WAIT_SWAP.
- Arithmetic and data:
  - Comparisons are unsigned.
  - The auto counter saturates, no wrap.
  - decimation=0 stores every valid sample.
  - sampleValid high on consecutive cycles is legal; each cycle is a separate sample.

Test Plan:
- Ramp 0..255 on sampleValid every cycle, trigLevel=100, rising, decimation=0, armEnable=1 -> first wrEn at wrAddr=0 with wrData=100; 640 consecutive writes of 100..255,0..; captureDone with wrAddr=639; state=3.
- Same capture, then vBlank pulses (high already at WAIT_SWAP entry, then low, then high) -> dispBank toggles 0->1 only on the second rising edge; wrBank=0; state returns to ARMED.
- Constant sampleData=50, trigLevel=100, autoMode=1, autoTimeout=20 -> trigger on the 20th valid sample; write at address 0 with data 50.
- decimation=3, triggered ramp -> stored data steps by 4 (e.g. 100,104,108...); wrEn spaced 4 valid samples apart.
- Assert vgaRst low mid-CAPTURE at wrAddr=300 -> all outputs reach their reset values immediately; after release with armEnable=0, state stays IDLE and no wrEn.
- Falling slope, sample sequence 120,90 with trigLevel=100, forceTrig and auto timeout coinciding on the 90 sample -> exactly one trigger and one write of 90 at address 0.

Source files
------------

// File: rtl/wave_capture_ctrl.sv
// Capture sequencer for the scope display: trigger detection, decimated writes into the
// back bank of a two-bank 640-entry waveform buffer, and a tear-free bank swap on vertical blank.
module wave_capture_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int AUTO_W    = 16
) (
  input  logic              Clk,
  input  logic              vgaRst,
  input  logic              sampleValid,
  input  logic [DATA_W-1:0] sampleData,
  input  logic              armEnable,
  input  logic              forceTrig,
  input  logic              trigSlope,
  input  logic [DATA_W-1:0] trigLevel,
  input  logic [7:0]        decimation,
  input  logic              autoMode,
  input  logic [AUTO_W-1:0] autoTimeout,
  input  logic              vBlank,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              wrBank,
  output logic              dispBank,
  output logic              captureDone,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    CAPTURE   = 2'd2,
    WAIT_SWAP = 2'd3
  } captureState_e;

  localparam logic [ADDR_W:0]   FRAME_LEN = (ADDR_W+1)'(H_VISIBLE);
  localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(H_VISIBLE - 1);
  localparam logic [AUTO_W-1:0] AUTO_ONE  = AUTO_W'(1);

  captureState_e     curState, nextState;
  logic [DATA_W-1:0] prevSample;
  logic              prevValid;
  logic [7:0]        decCnt;
  logic [AUTO_W-1:0] autoCnt;
  logic              vBlankPrev;
  logic              forcePending;
  logic [ADDR_W:0]   addrCnt;

  logic              levelHit, autoHit, forceHit;
  logic              armedTrig, captureStep, capWrite, swapEdge;
  logic [AUTO_W-1:0] autoLimit;

  assign autoLimit = autoTimeout - AUTO_ONE;
  assign state     = curState;
  assign wrBank    = ~dispBank;

  always_ff @(posedge Clk or negedge vgaRst) begin
    if (!vgaRst) curState <= IDLE;
    else         curState <= nextState;
  end

  // All trigger sources collapse into a single armedTrig, so coincident sources give one write.
  always_comb begin
    levelHit = 1'b0;
    if (prevValid) begin
      if (trigSlope) levelHit = (prevSample > trigLevel) && (sampleData <= trigLevel);
      else           levelHit = (prevSample < trigLevel) && (sampleData >= trigLevel);
    end
    autoHit     = autoMode && (autoCnt == autoLimit);
    forceHit    = forceTrig || forcePending;
    armedTrig   = (curState == ARMED) && armEnable && sampleValid &&
                  (levelHit || autoHit || forceHit);
    captureStep = (curState == CAPTURE) && sampleValid && (addrCnt < FRAME_LEN);
    capWrite    = captureStep && (decCnt == 8'd0);
    swapEdge    = (curState == WAIT_SWAP) && vBlank && !vBlankPrev;

    nextState = curState;
    case (curState)
      IDLE:      if (armEnable) nextState = ARMED;
      ARMED: begin
        if (!armEnable)     nextState = IDLE;
        else if (armedTrig) nextState = CAPTURE;
      end
      CAPTURE:   if (captureDone) nextState = WAIT_SWAP;
      WAIT_SWAP: if (swapEdge) nextState = armEnable ? ARMED : IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge vgaRst) begin
    if (!vgaRst) begin
      wrEn         <= 1'b0;
      wrAddr       <= '0;
      wrData       <= '0;
      captureDone  <= 1'b0;
      dispBank     <= 1'b0;
      prevSample   <= '0;
      prevValid    <= 1'b0;
      decCnt       <= 8'd0;
      autoCnt      <= '0;
      vBlankPrev   <= 1'b0;
      forcePending <= 1'b0;
      addrCnt      <= '0;
    end else begin
      vBlankPrev  <= vBlank;
      wrEn        <= armedTrig || capWrite;
      captureDone <= capWrite && (addrCnt == LAST_ADDR);

      if (armedTrig) begin
        wrAddr  <= '0;
        wrData  <= sampleData;
        addrCnt <= (ADDR_W+1)'(1);
        decCnt  <= decimation;
      end else if (captureStep) begin
        if (capWrite) begin
          wrAddr  <= addrCnt[ADDR_W-1:0];
          wrData  <= sampleData;
          addrCnt <= addrCnt + 1'b1;
          decCnt  <= decimation;
        end else begin
          decCnt  <= decCnt - 8'd1;
        end
      end

      if (curState == IDLE || swapEdge) begin
        prevValid <= 1'b0;
        autoCnt   <= '0;
      end else if (curState == ARMED && sampleValid) begin
        prevSample <= sampleData;
        prevValid  <= 1'b1;
        if (!armedTrig && autoCnt != '1) autoCnt <= autoCnt + AUTO_ONE;
      end

      // A forced trigger stays pending until the next valid sample while armed.
      if (curState != ARMED || armedTrig || !armEnable) forcePending <= 1'b0;
      else if (forceTrig)                               forcePending <= 1'b1;

      if (swapEdge) dispBank <= ~dispBank;
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: ramp capture, vblank swap, auto trigger,
// mid-capture reset, decimation and coincident falling/force/auto triggers.
module tb_wave_capture_ctrl;

  logic        Clk;
  logic        vgaRst;
  logic        sampleValid;
  logic [7:0]  sampleData;
  logic        armEnable;
  logic        forceTrig;
  logic        trigSlope;
  logic [7:0]  trigLevel;
  logic [7:0]  decimation;
  logic        autoMode;
  logic [15:0] autoTimeout;
  logic        vBlank;
  logic        wrEn;
  logic [9:0]  wrAddr;
  logic [7:0]  wrData;
  logic        wrBank;
  logic        dispBank;
  logic        captureDone;
  logic [1:0]  state;

  int checkCount = 0;
  int failCount  = 0;
  int writes;
  int doneCount;
  int badState;

  wave_capture_ctrl dut (
    .Clk(Clk), .vgaRst(vgaRst), .sampleValid(sampleValid), .sampleData(sampleData),
    .armEnable(armEnable), .forceTrig(forceTrig), .trigSlope(trigSlope),
    .trigLevel(trigLevel), .decimation(decimation), .autoMode(autoMode),
    .autoTimeout(autoTimeout), .vBlank(vBlank), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .wrBank(wrBank), .dispBank(dispBank), .captureDone(captureDone),
    .state(state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of sample input, then return 1 time unit after the edge that sampled it.
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    sampleValid = valid;
    sampleData  = data;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "State"}, 32'(state), 0);
    checkOutput({tag, "WrEn"}, 32'(wrEn), 0);
    checkOutput({tag, "WrAddr"}, 32'(wrAddr), 0);
    checkOutput({tag, "WrData"}, 32'(wrData), 0);
    checkOutput({tag, "DispBank"}, 32'(dispBank), 0);
    checkOutput({tag, "WrBank"}, 32'(wrBank), 1);
    checkOutput({tag, "Done"}, 32'(captureDone), 0);
  endtask

  task automatic resetDut();
    sampleValid = 1'b0;
    forceTrig   = 1'b0;
    vgaRst      = 1'b0;
    #1;
    vgaRst      = 1'b1;
  endtask

  initial begin
    vgaRst = 1'b0; sampleValid = 1'b0; sampleData = 8'd0; armEnable = 1'b0;
    forceTrig = 1'b0; trigSlope = 1'b0; trigLevel = 8'd0; decimation = 8'd0;
    autoMode = 1'b0; autoTimeout = 16'd0; vBlank = 1'b0;

    @(posedge Clk); #1;
    checkResetValues("init");
    vgaRst = 1'b1;

    // Rising ramp capture, vBlank already high so the entry into WAIT_SWAP sees no edge.
    armEnable = 1'b1; trigLevel = 8'd100; vBlank = 1'b1;
    applyStimulus(1'b0, 8'd0);
    checkOutput("armState", 32'(state), 1);
    writes = 0;
    for (int v = 0; v < 100; v++) begin
      applyStimulus(1'b1, 8'(v));
      if (wrEn) writes++;
    end
    checkOutput("preTrigWrites", writes, 0);
    applyStimulus(1'b1, 8'd100);
    checkOutput("trigWrEn", 32'(wrEn), 1);
    checkOutput("trigAddr", 32'(wrAddr), 0);
    checkOutput("trigData", 32'(wrData), 100);
    checkOutput("trigState", 32'(state), 2);
    doneCount = 0;
    for (int i = 1; i < 640; i++) begin
      applyStimulus(1'b1, 8'(100 + i));
      checkOutput("rampWrEn", 32'(wrEn), 1);
      checkOutput("rampAddr", 32'(wrAddr), 32'(i));
      checkOutput("rampData", 32'(wrData), 32'((100 + i) % 256));
      if (i < 639 && captureDone) doneCount++;
    end
    checkOutput("earlyDone", doneCount, 0);
    checkOutput("lastDone", 32'(captureDone), 1);
    applyStimulus(1'b1, 8'd5);
    checkOutput("waitState", 32'(state), 3);
    checkOutput("waitWrEn", 32'(wrEn), 0);
    checkOutput("waitDone", 32'(captureDone), 0);

    writes = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(k));
      if (wrEn) writes++;
    end
    checkOutput("waitIgnored", writes, 0);
    checkOutput("highEntryBank", 32'(dispBank), 0);
    vBlank = 1'b0;
    applyStimulus(1'b0, 8'd0);
    applyStimulus(1'b0, 8'd0);
    checkOutput("lowBank", 32'(dispBank), 0);
    checkOutput("lowState", 32'(state), 3);
    vBlank = 1'b1;
    applyStimulus(1'b0, 8'd0);
    checkOutput("swapDisp", 32'(dispBank), 1);
    checkOutput("swapWrBank", 32'(wrBank), 0);
    checkOutput("swapState", 32'(state), 1);

    // Auto trigger on the 20th constant sample, then reset in the middle of that capture.
    autoMode = 1'b1; autoTimeout = 16'd20; vBlank = 1'b0;
    writes = 0;
    for (int k = 1; k < 20; k++) begin
      applyStimulus(1'b1, 8'd50);
      if (wrEn) writes++;
    end
    checkOutput("autoEarly", writes, 0);
    applyStimulus(1'b1, 8'd50);
    checkOutput("autoWrEn", 32'(wrEn), 1);
    checkOutput("autoAddr", 32'(wrAddr), 0);
    checkOutput("autoData", 32'(wrData), 50);
    for (int k = 1; k <= 300; k++) applyStimulus(1'b1, 8'(k));
    checkOutput("midAddr", 32'(wrAddr), 300);
    checkOutput("midData", 32'(wrData), 44);
    checkOutput("midBank", 32'(dispBank), 1);
    vgaRst = 1'b0;
    #1;
    checkResetValues("midRst");
    armEnable = 1'b0; autoMode = 1'b0;
    #1;
    vgaRst = 1'b1;
    writes = 0; badState = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(90 + k * 7));
      if (wrEn) writes++;
      if (state != 2'd0) badState++;
    end
    checkOutput("postRstWrites", writes, 0);
    checkOutput("postRstState", badState, 0);

    // Decimation by 4 on a triggered ramp.
    resetDut();
    armEnable = 1'b1; decimation = 8'd3; trigLevel = 8'd100; trigSlope = 1'b0;
    applyStimulus(1'b0, 8'd0);
    checkOutput("decArm", 32'(state), 1);
    for (int v = 90; v < 100; v++) applyStimulus(1'b1, 8'(v));
    for (int v = 100; v < 132; v++) begin
      applyStimulus(1'b1, 8'(v));
      checkOutput("decWrEn", 32'(wrEn), 32'(((v - 100) % 4) == 0));
      if (((v - 100) % 4) == 0) begin
        checkOutput("decData", 32'(wrData), 32'(v));
        checkOutput("decAddr", 32'(wrAddr), 32'((v - 100) / 4));
      end
    end

    // Falling slope with force and auto timeout landing on the same sample.
    resetDut();
    armEnable = 1'b1; decimation = 8'd0; trigSlope = 1'b1; trigLevel = 8'd100;
    autoMode = 1'b1; autoTimeout = 16'd2;
    applyStimulus(1'b0, 8'd0);
    checkOutput("fallArm", 32'(state), 1);
    applyStimulus(1'b1, 8'd120);
    checkOutput("fallFirst", 32'(wrEn), 0);
    forceTrig = 1'b1;
    applyStimulus(1'b1, 8'd90);
    forceTrig = 1'b0;
    checkOutput("fallWrEn", 32'(wrEn), 1);
    checkOutput("fallAddr", 32'(wrAddr), 0);
    checkOutput("fallData", 32'(wrData), 90);
    applyStimulus(1'b0, 8'd0);
    checkOutput("fallSingle", 32'(wrEn), 0);
    applyStimulus(1'b1, 8'd80);
    checkOutput("fallNextAddr", 32'(wrAddr), 1);
    checkOutput("fallNextData", 32'(wrData), 80);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
